ws2811_frame_sequencer: RTL and testbench

WS2811_FRAME_SEQUENCER -- requirements
Module: ws2811_frame_sequencer

---
 rtl/ws2811_frame_sequencer_if.sv | 22 ++
 rtl/ws2811_frame_sequencer.sv | 111 +++++++++++
 tb/tb_ws2811_frame_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/ws2811_frame_sequencer_if.sv
// Pixel-memory read port and pixel-word handshake between the frame sequencer
// (master) and the memory / bit-encoder side (slave).
interface ws2811_frame_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [23:0]       mem_data;
    logic [23:0]       pix_data;
    logic              pix_valid;
    logic              pix_ready;

    modport master (
        output mem_addr, mem_rd, pix_data, pix_valid,
        input  mem_data, pix_ready
    );

    modport slave (
        input  mem_addr, mem_rd, pix_data, pix_valid,
        output mem_data, pix_ready
    );
endinterface

// File: rtl/ws2811_frame_sequencer.sv
// Walks pixel memory once per frame, hands each GRB word to the bit encoder,
// then holds the WS2811 latch gap. Frames come from start or a periodic timer.
module ws2811_frame_sequencer #(
    parameter int NUM_PIXELS   = 50,
    parameter int ADDR_W       = 8,
    parameter int LATCH_CYCLES = 800,
    parameter int FRAME_PERIOD = 266_667
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            start,
    input  logic                            auto_en,
    ws2811_frame_sequencer_if.master        bus,
    output logic                            busy,
    output logic                            frame_done
);
    localparam int IDX_W = (NUM_PIXELS > 1)   ? $clog2(NUM_PIXELS)   : 1;
    localparam int LAT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam int FRM_W = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PIXELS - 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATCH_CYCLES - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAME_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        WAIT    = 3'd2,
        PRESENT = 3'd3,
        LATCH   = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [LAT_W-1:0]  lat_cnt;
    logic [FRM_W-1:0]  frm_cnt;
    logic              pending;
    logic [23:0]       pix_word;

    logic tick;
    logic req;
    logic trigger;
    logic handshake;
    logic last_pix;
    logic lat_zero;

    assign tick      = (frm_cnt == FRM_LAST);
    assign req       = start | (tick & auto_en);
    // A request seen while busy is parked in pending and picked up from IDLE.
    assign trigger   = req | pending;
    assign handshake = (state == PRESENT) & bus.pix_ready;
    assign last_pix  = (idx == IDX_LAST);
    assign lat_zero  = (lat_cnt == '0);

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trigger) state_nxt = FETCH;
            FETCH:   state_nxt = WAIT;
            WAIT:    state_nxt = PRESENT;
            PRESENT: if (handshake) state_nxt = last_pix ? LATCH : FETCH;
            LATCH:   if (lat_zero) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state != IDLE);
        bus.mem_rd    = (state == FETCH);
        bus.mem_addr  = ADDR_W'(idx);
        bus.pix_valid = (state == PRESENT);
        bus.pix_data  = pix_word;
        frame_done    = (state == LATCH) & lat_zero;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            idx      <= '0;
            lat_cnt  <= '0;
            frm_cnt  <= '0;
            pending  <= 1'b0;
            pix_word <= '0;
        end else begin
            frm_cnt <= tick ? '0 : frm_cnt + 1'b1;

            // IDLE always consumes pending, so clearing it there is the same
            // as clearing it on the trigger that leaves IDLE.
            if (state == IDLE)  pending <= 1'b0;
            else if (req)       pending <= 1'b1;

            case (state)
                IDLE:    if (trigger) idx <= '0;
                WAIT:    pix_word <= bus.mem_data;
                PRESENT: begin
                    if (handshake) begin
                        if (last_pix) lat_cnt <= LAT_LOAD;
                        else          idx     <= idx + 1'b1;
                    end
                end
                LATCH:   if (!lat_zero) lat_cnt <= lat_cnt - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ws2811_frame_sequencer.sv
// Directed bench: 3-pixel frames, 800-cycle latch, 2000-cycle auto period,
// memory model returning 0xA0 + address one cycle after each read.
module tb_ws2811_frame_sequencer;
    logic CLK;
    logic RST;
    logic start;
    logic auto_en;
    logic busy;
    logic frame_done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int s;
    int at;
    int t1, t2, t3;
    int errs;

    ws2811_frame_sequencer_if #(.ADDR_W(8)) bus ();

    ws2811_frame_sequencer #(
        .NUM_PIXELS  (3),
        .ADDR_W      (8),
        .LATCH_CYCLES(800),
        .FRAME_PERIOD(2000)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .auto_en   (auto_en),
        .bus       (bus.master),
        .busy      (busy),
        .frame_done(frame_done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Garbage outside the read-response slot exposes off-by-one capture timing.
    always_ff @(posedge CLK)
        bus.mem_data <= bus.mem_rd ? (24'hA0 + 24'(bus.mem_addr)) : 24'hBAD000;

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_fd(input int budget, output int when);
        when = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (frame_done) begin
                when = cyc;
                break;
            end
        end
    endtask

    task automatic wait_rd(input int budget, output int when);
        when = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (bus.mem_rd && bus.mem_addr == 8'd0) begin
                when = cyc;
                break;
            end
        end
    endtask

    initial begin
        RST = 1'b1;
        start = 1'b0;
        auto_en = 1'b0;
        bus.pix_ready = 1'b1;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_mem_rd", bus.mem_rd, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_pix_valid", bus.pix_valid, 0);
        chk("rst_pix_data", bus.pix_data, 0);
        chk("rst_frame_done", frame_done, 0);
        RST = 1'b0;
        repeat (6) tick();

        // basic frame, ready tied high
        start = 1'b1; s = cyc; tick(); start = 1'b0;
        chk("a_rd0", bus.mem_rd, 1);
        chk("a_addr0", bus.mem_addr, 0);
        chk("a_busy", busy, 1);
        chk("a_pv_fetch", bus.pix_valid, 0);
        tick();
        chk("a_rd_wait", bus.mem_rd, 0);
        chk("a_pv_wait", bus.pix_valid, 0);
        tick();
        chk("a_pv0", bus.pix_valid, 1);
        chk("a_pd0", bus.pix_data, 24'hA0);
        tick();
        chk("a_rd1", bus.mem_rd, 1);
        chk("a_addr1", bus.mem_addr, 1);
        chk("a_pv_fetch1", bus.pix_valid, 0);
        tick(); tick();
        chk("a_pv1", bus.pix_valid, 1);
        chk("a_pd1", bus.pix_data, 24'hA1);
        tick();
        chk("a_rd2", bus.mem_rd, 1);
        chk("a_addr2", bus.mem_addr, 2);
        tick(); tick();
        chk("a_pv2", bus.pix_valid, 1);
        chk("a_pd2", bus.pix_data, 24'hA2);
        errs = 0;
        for (int i = 0; i < 799; i++) begin
            tick();
            if (frame_done || bus.pix_valid || bus.mem_rd) errs++;
        end
        chk("a_latch_quiet", errs, 0);
        chk("a_latch_busy", busy, 1);
        tick();
        chk("a_frame_done", frame_done, 1);
        tick();
        chk("a_fd_width", frame_done, 0);
        chk("a_busy_after", busy, 0);

        // stall in PRESENT with two extra starts arriving mid-frame
        bus.pix_ready = 1'b0;
        start = 1'b1; s = cyc; tick(); start = 1'b0;
        tick(); tick();
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.pix_valid !== 1'b1 || bus.pix_data !== 24'hA0 || bus.mem_rd !== 1'b0) errs++;
            if (i == 3 || i == 10) start = 1'b1;
            tick();
            start = 1'b0;
        end
        chk("b_stall_stable", errs, 0);
        bus.pix_ready = 1'b1;
        wait_fd(900, at);
        chk("b_frame_done_at", at, s + 829);
        tick();
        chk("b_idle_gap", busy, 0);
        tick();
        chk("b_extra_rd", bus.mem_rd, 1);
        chk("b_extra_addr", bus.mem_addr, 0);
        wait_fd(900, at);
        chk("b_extra_done_at", at, s + 1639);
        errs = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (bus.mem_rd || busy) errs++;
        end
        chk("b_no_third", errs, 0);

        // auto refresh every FRAME_PERIOD cycles
        auto_en = 1'b1;
        wait_rd(2100, t1);
        chk("c_auto_first", (t1 >= 0), 1);
        wait_fd(900, at);
        chk("c_auto_done", at, t1 + 808);
        wait_rd(2100, t2);
        chk("c_period1", t2 - t1, 2000);
        wait_fd(900, at);
        wait_rd(2100, t3);
        chk("c_period2", t3 - t2, 2000);
        wait_fd(900, at);
        auto_en = 1'b0;
        errs = 0;
        for (int i = 0; i < 4500; i++) begin
            tick();
            if (bus.mem_rd || busy) errs++;
        end
        chk("c_auto_off", errs, 0);

        // reset while presenting pixel 1
        start = 1'b1; s = cyc; tick(); start = 1'b0;
        repeat (5) tick();
        chk("d_pv1", bus.pix_valid, 1);
        chk("d_pd1", bus.pix_data, 24'hA1);
        RST = 1'b1;
        tick();
        chk("d_rst_busy", busy, 0);
        chk("d_rst_rd", bus.mem_rd, 0);
        chk("d_rst_addr", bus.mem_addr, 0);
        chk("d_rst_pv", bus.pix_valid, 0);
        chk("d_rst_pd", bus.pix_data, 0);
        chk("d_rst_fd", frame_done, 0);
        RST = 1'b0;
        errs = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (frame_done || busy) errs++;
        end
        chk("d_no_done", errs, 0);
        start = 1'b1; tick(); start = 1'b0;
        chk("d_restart_rd", bus.mem_rd, 1);
        chk("d_restart_addr", bus.mem_addr, 0);
        tick(); tick();
        chk("d_restart_pv", bus.pix_valid, 1);
        chk("d_restart_pd", bus.pix_data, 24'hA0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
